fsqrt: RTL and testbench

- Pipelined IEEE-754 single-precision square root unit for the FPU datapath.
- Accepts one operand every clock and returns a correctly rounded (round-to-nearest) result a fixed 3 cycles later.
- No handshake: the surrounding pipeline tracks validity by the fixed latency.

---
 rtl/fsqrt.sv | 208 ++++++++++++++++++++
 tb/tb_fsqrt.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fsqrt.sv
// fsqrt: pipelined IEEE-754 binary32 square root, round-to-nearest.
// One operand per clock, result on y three clock edges later.
// The 25 root bits come from a restoring digit recurrence (two radicand bits
// in, one root bit out per iteration), unrolled 9/8/8 across three stages.
// Zero, denormal, negative, NaN and infinity operands are resolved in stage 1
// and ride down the pipe as a flag plus a ready-made result word.

module fsqrt (
   input  logic [31:0] x,
   output logic [31:0] y,
   input  logic        clk,
   input  logic        rstn
);

   localparam logic [31:0] QNAN   = 32'h7FC00000;
   localparam logic [31:0] POSINF = 32'h7F800000;

   // Partial remainder and partial root of the digit recurrence.
   // The remainder never exceeds twice the partial root, so 27 bits suffice.
   typedef struct packed {
      logic [26:0] rem;
      logic [24:0] root;
   } sqrtState_t;

   // One restoring iteration: bring down the next radicand bit pair and try
   // to append a 1 to the root, i.e. subtract (4*root + 1).
   function automatic sqrtState_t sqrtStep(input sqrtState_t cur, input logic [1:0] pair);
      sqrtState_t nxt;
      logic [28:0] shifted;
      logic [28:0] trial;
      shifted = {cur.rem, pair};
      trial   = {2'b00, cur.root, 2'b01};
      if (shifted >= trial) begin
         nxt.rem  = shifted[26:0] - trial[26:0];
         nxt.root = {cur.root[23:0], 1'b1};
      end else begin
         nxt.rem  = shifted[26:0];
         nxt.root = {cur.root[23:0], 1'b0};
      end
      return nxt;
   endfunction

   // The last iteration only needs the root bit; its remainder is never used
   // because exact ties cannot occur for a square root.
   function automatic logic lastRootBit(input sqrtState_t cur, input logic [1:0] pair);
      return ({cur.rem, pair} >= {2'b00, cur.root, 2'b01});
   endfunction

   // ------------------------------------------------------------------
   // Stage 1: decode, special-case detection, first 9 root bits
   // ------------------------------------------------------------------
   logic        w_sign;
   logic [7:0]  w_exp;
   logic [22:0] w_frac;
   logic [49:0] w_rad;
   logic [7:0]  w_ey;
   logic        w_special;
   logic [31:0] w_specVal;
   sqrtState_t  w_st1;

   assign w_sign = x[31];
   assign w_exp  = x[30:23];
   assign w_frac = x[22:0];

   // Even biased exponent means an odd true exponent, so the significand is
   // pre-shifted one extra place to make the remaining exponent even.
   // (e + 127) >> 1 is written as e[7:1] + 63 + e[0], which is the same value
   // without a dropped LSB; the maximum is 190 so 8 bits never overflow.
   always_comb begin
      w_rad = w_exp[0] ? {1'b0, 1'b1, w_frac, 25'b0} : {1'b1, w_frac, 26'b0};
      w_ey  = {1'b0, w_exp[7:1]} + 8'd63 + {7'b0, w_exp[0]};
   end

   // Classify the operand; anything that is not a positive normal number
   // bypasses the arithmetic with its final answer chosen here.
   always_comb begin
      w_special = 1'b0;
      w_specVal = 32'h00000000;
      if (w_exp == 8'd0) begin
         w_special = 1'b1;
         w_specVal = {w_sign, 31'b0};
      end else if (w_sign) begin
         w_special = 1'b1;
         w_specVal = QNAN;
      end else if (w_exp == 8'hFF) begin
         w_special = 1'b1;
         w_specVal = (w_frac != 23'd0) ? QNAN : POSINF;
      end
   end

   // First nine recurrence iterations over radicand bits [49:32].
   always_comb begin
      w_st1 = '0;
      for (int i = 0; i < 9; i++) begin
         w_st1 = sqrtStep(w_st1, w_rad[49-2*i -: 2]);
      end
   end

   logic [26:0] r_s1Rem;
   logic [24:0] r_s1Root;
   logic [31:0] r_s1Rad;
   logic [7:0]  r_s1Ey;
   logic        r_s1Special;
   logic [31:0] r_s1SpecVal;

   // Stage 1 register: partial recurrence state plus the unconsumed radicand.
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_s1Rem     <= '0;
         r_s1Root    <= '0;
         r_s1Rad     <= '0;
         r_s1Ey      <= '0;
         r_s1Special <= 1'b0;
         r_s1SpecVal <= '0;
      end else begin
         r_s1Rem     <= w_st1.rem;
         r_s1Root    <= w_st1.root;
         r_s1Rad     <= w_rad[31:0];
         r_s1Ey      <= w_ey;
         r_s1Special <= w_special;
         r_s1SpecVal <= w_specVal;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: next 8 root bits
   // ------------------------------------------------------------------
   sqrtState_t w_st2;

   // Iterations 10..17 over radicand bits [31:16].
   always_comb begin
      w_st2.rem  = r_s1Rem;
      w_st2.root = r_s1Root;
      for (int i = 0; i < 8; i++) begin
         w_st2 = sqrtStep(w_st2, r_s1Rad[31-2*i -: 2]);
      end
   end

   logic [26:0] r_s2Rem;
   logic [24:0] r_s2Root;
   logic [15:0] r_s2Rad;
   logic [7:0]  r_s2Ey;
   logic        r_s2Special;
   logic [31:0] r_s2SpecVal;

   // Stage 2 register.
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_s2Rem     <= '0;
         r_s2Root    <= '0;
         r_s2Rad     <= '0;
         r_s2Ey      <= '0;
         r_s2Special <= 1'b0;
         r_s2SpecVal <= '0;
      end else begin
         r_s2Rem     <= w_st2.rem;
         r_s2Root    <= w_st2.root;
         r_s2Rad     <= r_s1Rad[15:0];
         r_s2Ey      <= r_s1Ey;
         r_s2Special <= r_s1Special;
         r_s2SpecVal <= r_s1SpecVal;
      end
   end

   // ------------------------------------------------------------------
   // Stage 3: last 8 root bits, rounding, result assembly
   // ------------------------------------------------------------------
   sqrtState_t  w_st3;
   logic [24:0] w_root;
   logic [24:0] w_sum;
   logic [22:0] w_mant;
   logic [7:0]  w_eyOut;
   logic [31:0] w_result;

   // Iterations 18..24 keep full state; iteration 25 only yields the root LSB.
   always_comb begin
      w_st3.rem  = r_s2Rem;
      w_st3.root = r_s2Root;
      for (int i = 0; i < 7; i++) begin
         w_st3 = sqrtStep(w_st3, r_s2Rad[15-2*i -: 2]);
      end
      w_root = {w_st3.root[23:0], lastRootBit(w_st3, r_s2Rad[1:0])};
   end

   // Round the 24-bit significand r[24:1] with r[0] as the round bit. A carry
   // out makes the sum exactly 2^24, whose bits [23:1] are zero, which is the
   // required mantissa when the exponent bumps.
   always_comb begin
      w_sum    = {1'b0, w_root[24:1]} + {24'b0, w_root[0]};
      w_mant   = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
      w_eyOut  = r_s2Ey + {7'b0, w_sum[24]};
      w_result = r_s2Special ? r_s2SpecVal : {1'b0, w_eyOut, w_mant};
   end

   logic [31:0] r_y;

   // Output register; y is driven straight from it.
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_y <= 32'h00000000;
      end else begin
         r_y <= w_result;
      end
   end

   assign y = r_y;

endmodule

// File: tb/tb_fsqrt.sv
// tb_fsqrt: scoreboard bench for the fsqrt pipeline.
// The stimulus side queues each operand with the cycle it was driven and its
// expected result; the monitor pops entries as they come due three edges later.
// Expected values come from directed constants or from an integer model of
// correctly rounded sqrt that works on the real value, not on a recurrence.

module tb_fsqrt;

   logic        clk;
   logic        rstn;
   logic [31:0] x;
   logic [31:0] y;

   int cnt;
   int checks;
   int errors;

   typedef struct {
      int          cyc;
      logic [31:0] x;
      logic [31:0] exp;
      string       tag;
   } entry_t;

   entry_t sb[$];

   fsqrt dut (
      .x    (x),
      .y    (y),
      .clk  (clk),
      .rstn (rstn)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count rising edges so entries can be matched to their due cycle.
   initial cnt = 0;
   always @(posedge clk) cnt <= cnt + 1;

   // Floor of the integer square root by binary search.
   function automatic longint isqrt(input longint v);
      longint lo, hi, mid;
      lo = 0;
      hi = longint'(1) << 26;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= v) lo = mid;
         else hi = mid - 1;
      end
      return lo;
   endfunction

   // Reference: flush/NaN/inf rules, otherwise sqrt of 1.f * 2^ue rounded to
   // nearest 24-bit significand by comparing against the half-way point.
   function automatic logic [31:0] refSqrt(input logic [31:0] a);
      int     e, ue, ex;
      longint m, rr, s0;
      logic [7:0]  exb;
      logic [22:0] mb;
      e = int'({24'b0, a[30:23]});
      if (e == 0) return {a[31], 31'b0};
      if (a[31]) return 32'h7FC00000;
      if (e == 255) return (a[22:0] != 23'd0) ? 32'h7FC00000 : 32'h7F800000;
      m  = longint'({1'b1, a[22:0]});
      ue = e - 127;
      if (ue % 2 != 0) begin
         m  = m * 2;
         ue = ue - 1;
      end
      rr = m << 23;
      s0 = isqrt(rr);
      if ((2 * s0 + 1) * (2 * s0 + 1) < 4 * rr) s0 = s0 + 1;
      ex = ue / 2 + 127;
      if (s0 == (longint'(1) << 24)) begin
         s0 = longint'(1) << 23;
         ex = ex + 1;
      end
      exb = ex[7:0];
      mb  = s0[22:0];
      return {1'b0, exb, mb};
   endfunction

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string name, input logic [31:0] xin,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: x=%h y=%h expected=%h", name, xin, act, exp);
      end
   endtask

   // Drive one operand at the falling edge and queue its expected result.
   // Asserting reset voids every operand still inside the pipe.
   task automatic applyStimulus(input logic [31:0] v, input logic rst,
                                input logic [31:0] exp, input string tag);
      entry_t ent;
      @(negedge clk);
      x    = v;
      rstn = rst;
      if (rst) begin
         foreach (sb[i]) begin
            if (sb[i].cyc >= cnt - 2) sb[i].exp = 32'h00000000;
         end
      end
      ent.cyc = cnt;
      ent.x   = v;
      ent.exp = rst ? 32'h00000000 : exp;
      ent.tag = tag;
      sb.push_back(ent);
   endtask

   function automatic logic [31:0] randOperand();
      logic [31:0] v;
      v = $urandom;
      if ($urandom_range(0, 3) != 0) v[31] = 1'b0;
      return v;
   endfunction

   // Monitor: compare each entry exactly three edges after it was sampled.
   initial begin
      entry_t ent;
      forever begin
         @(posedge clk);
         #1;
         while (sb.size() > 0 && sb[0].cyc + 3 < cnt) begin
            ent = sb.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL %s: x=%h result never compared, due cycle %0d now %0d",
                     ent.tag, ent.x, ent.cyc + 3, cnt);
         end
         if (sb.size() > 0 && sb[0].cyc + 3 == cnt) begin
            ent = sb.pop_front();
            checkOutput(ent.tag, ent.x, y, ent.exp);
         end
      end
   end

   logic [31:0] dirX   [12] = '{32'h40800000, 32'h3F800000, 32'h41100000,
                                32'h40000000, 32'h7F7FFFFF, 32'h00800000,
                                32'h00000000, 32'h80000000, 32'h00000001,
                                32'h7F800000, 32'hBF800000, 32'h7FA00000};
   logic [31:0] dirExp [12] = '{32'h40000000, 32'h3F800000, 32'h40400000,
                                32'h3FB504F3, 32'h5F7FFFFF, 32'h20000000,
                                32'h00000000, 32'h80000000, 32'h00000000,
                                32'h7F800000, 32'h7FC00000, 32'h7FC00000};

   // Main stimulus sequence.
   initial begin
      logic [31:0] v;
      checks = 0;
      errors = 0;
      rstn   = 1'b1;
      x      = 32'h0;

      // Held reset with random operands: y must stay zero.
      for (int i = 0; i < 20; i++) begin
         applyStimulus($urandom, 1'b1, 32'h0, "reset_hold");
         checkOutput("reset_y", x, y, 32'h00000000);
      end

      // Directed exact squares, rounding cases and specials.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(dirX[i], 1'b0, dirExp[i], "directed");
      end

      // Back-to-back random stream.
      for (int i = 0; i < 255; i++) begin
         v = randOperand();
         applyStimulus(v, 1'b0, refSqrt(v), "stream");
      end

      // Reset pulse with three operands in flight, then resume.
      for (int i = 0; i < 3; i++) begin
         v = randOperand();
         applyStimulus(v, 1'b0, refSqrt(v), "pre_reset");
      end
      applyStimulus(randOperand(), 1'b1, 32'h0, "reset_pulse");
      for (int i = 0; i < 6; i++) begin
         v = randOperand();
         applyStimulus(v, 1'b0, refSqrt(v), "post_reset");
      end

      // Drain the scoreboard with a bounded wait.
      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: %0d entries left, required 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
